// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the line arbiter.
// master = arbiter view, slave = caches/memory view.
interface mem_arbiter_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_rdy;
  logic [LINE_W-1:0] ic_data;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_rdy;
  logic [LINE_W-1:0] dc_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rdy;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_rdy, mem_rdata,
    output ic_rdy, ic_data,
    output dc_rdy, dc_data,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_rdy, mem_rdata,
    input  ic_rdy, ic_data,
    input  dc_rdy, dc_data,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IC/DC arbiter for the shared memory line port.
// MEM_ARB_TIMEOUT_EN adds a WAIT timeout with a one-cycle err pulse.
module mem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic clk,
  input  logic rst,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic err,
`endif
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  logic              pick_dc;
  logic              gnt_dc;
  logic              last_dc;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ic_rdy_q;
  logic              dc_rdy_q;
  logic [LINE_W-1:0] ic_data_q;
  logic [LINE_W-1:0] dc_data_q;
  logic              done;
  logic              tmo;
  logic [LINE_W-1:0] rsp;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign tmo = (state == WAIT) && !bus.mem_rdy &&
               (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    // On a tie the requester that was not served last wins
    pick_dc = bus.dc_req & (~bus.ic_req | ~last_dc);
    unique case (state)
      IDLE:  if (bus.ic_req | bus.dc_req) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT:  if (bus.mem_rdy | tmo) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign done = (state == WAIT) && (state_n == RESP);
  assign rsp  = (we_q | tmo) ? '0 : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_dc    <= 1'b0;
      last_dc   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ic_rdy_q  <= 1'b0;
      dc_rdy_q  <= 1'b0;
      ic_data_q <= '0;
      dc_data_q <= '0;
    end else begin
      ic_rdy_q <= 1'b0;
      dc_rdy_q <= 1'b0;
      if (state == IDLE && (bus.ic_req | bus.dc_req)) begin
        gnt_dc  <= pick_dc;
        addr_q  <= pick_dc ? bus.dc_addr : bus.ic_addr;
        we_q    <= pick_dc & bus.dc_we;
        wdata_q <= pick_dc ? bus.dc_wdata : '0;
      end
      if (done) begin
        if (gnt_dc) begin
          dc_rdy_q  <= 1'b1;
          dc_data_q <= rsp;
        end else begin
          ic_rdy_q  <= 1'b1;
          ic_data_q <= rsp;
        end
      end
      if (state == RESP) last_dc <= gnt_dc;
    end
  end

  assign bus.mem_req   = (state == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ic_rdy    = ic_rdy_q;
  assign bus.ic_data   = ic_data_q;
  assign bus.dc_rdy    = dc_rdy_q;
  assign bus.dc_data   = dc_data_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main_memory line port between the instruction cache (IC) and the data cache (DC).
- Each requester holds a request. The arbiter grants one requester at a time and issues a one-cycle load/store pulse to memory. It then waits for the memory ready pulse and returns the 128-bit line, plus a one-cycle ready, to the granted requester.
- Sits between the cache miss handlers and main_memory. Its memory-side signals drive the memory's bus producer modport.

Parameters:
- LINE_W, ICLLEN (128): width of a cache line / memory data word.
- ADDR_W, 32: byte address width.
- TIMEOUT_CYC, 64: maximum cycles spent in WAIT. Used only under the optional feature.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ic_req  in  1  IC line-fill request; held until ic_rdy.
- ic_addr  in  ADDR_W  IC line address; stable while ic_req.
- ic_rdy  out  1  one-cycle completion pulse to IC.
- ic_data  out  LINE_W  fill line; valid when ic_rdy.
- dc_req  in  1  DC request; held until dc_rdy.
- dc_we  in  1  1 = line write-back, 0 = line fill.
- dc_addr  in  ADDR_W  DC line address.
- dc_wdata  in  LINE_W  write-back line.
- dc_rdy  out  1  one-cycle completion pulse to DC.
- dc_data  out  LINE_W  fill line; valid when dc_rdy. 0 on write completion.
- mem_req  out  1  memory request pulse (bus ldp).
- mem_we  out  1  write qualifier for mem_req.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  LINE_W  latched write data.
- mem_rdy  in  1  memory ready pulse (bus ldr).
- mem_rdata  in  LINE_W  memory line (bus ldData).
- err  out  1  timeout pulse. Present only with MEM_ARB_TIMEOUT_EN.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0.
  - Internal response register 0.
  - last_gnt = DC, so IC wins the first tie.
  - Reset in any state abandons the transaction; no rdy pulse is produced.
- State machine:
  - IDLE: no request keeps IDLE. Otherwise arbitrate:
    - Single request: grant it.
    - Both requesting: grant the requester that is not last_gnt (round-robin).
    - Latch gnt_id, addr, we (DC only; IC is always read) and wdata, then go to ISSUE.
  - ISSUE: mem_req=1 for exactly this cycle, with mem_addr/mem_we/mem_wdata driven from the latches. Go to WAIT.
  - WAIT: mem_req=0; mem_addr/we/wdata stay held.
    - On mem_rdy: capture mem_rdata (forced to 0 for writes) and go to RESP.
    - mem_rdy in any state other than WAIT is ignored.
  - RESP: assert the rdy of gnt_id for one cycle with the captured data. Set last_gnt=gnt_id and go to IDLE.
- Output timing:
  - rdy/data outputs are registered; the non-granted rdy is always 0.
  - ic_data/dc_data hold their last value between pulses.
- Latency:
  - req seen at cycle 0 → mem_req at cycle 1.
  - With a 1-cycle memory: mem_rdy at cycle 2, requester rdy at cycle 3.
  - Back-to-back transactions have a minimum 4-cycle period. IDLE is always visited, so no request can starve.
- Requester rules:
  - A requester must keep req high until its rdy.
  - Dropping req after the grant does not abort the transaction; the rdy pulse is still produced.
  - A requester whose req remains high in the cycle after its rdy is treated as a new request.
- Simultaneous events:
  - A new request arriving during ISSUE/WAIT/RESP waits for IDLE.
  - Two requests arriving together follow the round-robin rule above.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without mem_rdy, go to RESP with data 0, pulse err for one cycle alongside the requester rdy, and return to IDLE.
  - A late mem_rdy is ignored.
- When undefined: the err port and counter are absent, and WAIT waits indefinitely.

Test Plan:
- Single IC read: ic_req with ic_addr=0x0000_0040, memory returns 0xfe1088e3_0040a103_0010a223_40010093 one cycle after mem_req → mem_req pulse at cycle 1 with mem_addr=0x40, mem_we=0; ic_rdy at cycle 3 with ic_data equal to that line; dc_rdy stays 0.
- Tie after reset: ic_req and dc_req together at cycle 0 → IC is granted first and ic_rdy occurs at cycle 3. DC's mem_req occurs at cycle 5 and dc_rdy at cycle 7.
- Fairness under continuous requests: both requests held for 8 transactions → grants alternate IC, DC, IC, DC…; exactly one mem_req per transaction.
- DC write-back: dc_req=1, dc_we=1, dc_addr=0x100, dc_wdata=128'hA5…A5 → mem_we=1, mem_wdata=A5…A5 during the mem_req cycle; dc_rdy with dc_data=0.
- Reset mid-operation: assert rst for 1 cycle while in WAIT → all outputs 0 next cycle; no rdy pulse; a subsequent dc_req completes normally with DC granted (last_gnt reset to DC still gives IC the first tie).
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=4), memory never ready → err and ic_rdy pulse together with ic_data=0, 4 WAIT cycles after mem_req; a later stray mem_rdy produces no pulse.
